// File: rtl/serial_deserializer.sv
// Receive end of an LSB-first serial link: collects framed bits into an N-bit word
// and presents completed words on a one-entry valid/ready register with sticky error flags.
module serial_deserializer #(
    parameter int N = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Ser_Valid,
    input  logic                 Ser_In,
    input  logic                 Frame_Start,
    input  logic                 Dout_Ready,
    input  logic                 Clear_Err,
    output logic [N-1:0]         Dout,
    output logic                 Dout_Valid,
    output logic                 Busy,
    output logic [$clog2(N):0]   Bit_Count,
    output logic                 Overrun,
    output logic                 Frame_Err
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [N-1:0]  shreg_reg, shreg_next;
    logic [N-1:0]  shifted;
    logic [CW-1:0] count_reg, count_next;
    logic [N-1:0]  dout_reg, dout_next;
    logic          dout_valid_reg, dout_valid_next;
    logic          overrun_reg, overrun_next;
    logic          frame_err_reg, frame_err_next;
    logic          word_done;
    logic          overrun_set;
    logic          frame_err_set;

    // Right shift: the newest bit enters at the MSB, so bit 0 of the word arrives first.
    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_shift
            assign shifted[gi] = shreg_reg[gi + 1];
        end
    endgenerate
    assign shifted[N-1] = Ser_In;

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        count_next      = count_reg;
        dout_next       = dout_reg;
        dout_valid_next = dout_valid_reg;
        word_done       = 1'b0;
        overrun_set     = 1'b0;
        frame_err_set   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (Ser_Valid && Frame_Start) begin
                    shreg_next = shifted;
                    count_next = CW'(1);
                    state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (Ser_Valid) begin
                    shreg_next = shifted;
                    if (Frame_Start) begin
                        // Restart: the stale partial bits are flushed out by the next N shifts.
                        count_next    = CW'(1);
                        frame_err_set = 1'b1;
                    end else if (count_reg == CW'(N - 1)) begin
                        word_done  = 1'b1;
                        count_next = '0;
                        state_next = ST_IDLE;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (word_done) begin
            if (!dout_valid_reg || Dout_Ready) begin
                dout_next       = shifted;
                dout_valid_next = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (dout_valid_reg && Dout_Ready) begin
            dout_valid_next = 1'b0;
        end

        // A set in the same cycle as a clear takes priority.
        overrun_next   = overrun_set   | (overrun_reg   & ~Clear_Err);
        frame_err_next = frame_err_set | (frame_err_reg & ~Clear_Err);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            shreg_reg      <= '0;
            count_reg      <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            count_reg      <= count_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            overrun_reg    <= overrun_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign Dout       = dout_reg;
    assign Dout_Valid = dout_valid_reg;
    assign Busy       = (state_reg == ST_RECV);
    assign Bit_Count  = count_reg;
    assign Overrun    = overrun_reg;
    assign Frame_Err  = frame_err_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized and directed bench for serial_deserializer against a queue-based frame model.
module tb_serial_deserializer;

    localparam int N  = 8;
    localparam int CW = $clog2(N) + 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Ser_Valid = 1'b0;
    logic          Ser_In = 1'b0;
    logic          Frame_Start = 1'b0;
    logic          Dout_Ready = 1'b0;
    logic          Clear_Err = 1'b0;
    logic [N-1:0]  Dout;
    logic          Dout_Valid;
    logic          Busy;
    logic [CW-1:0] Bit_Count;
    logic          Overrun;
    logic          Frame_Err;

    serial_deserializer #(.N(N)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Ser_Valid  (Ser_Valid),
        .Ser_In     (Ser_In),
        .Frame_Start(Frame_Start),
        .Dout_Ready (Dout_Ready),
        .Clear_Err  (Clear_Err),
        .Dout       (Dout),
        .Dout_Valid (Dout_Valid),
        .Busy       (Busy),
        .Bit_Count  (Bit_Count),
        .Overrun    (Overrun),
        .Frame_Err  (Frame_Err)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a frame is just the list of bits collected so far.
    bit           m_in_frame;
    bit           m_bits[$];
    logic [N-1:0] m_dout;
    bit           m_valid;
    bit           m_ovr;
    bit           m_ferr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic sv, input logic si, input logic fs,
                              input logic rdy, input logic clr, input logic rst);
        bit           done;
        bit           ovr_set;
        bit           ferr_set;
        int unsigned  word;
        done     = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        word     = 0;
        if (rst) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            if (sv) begin
                if (fs) begin
                    if (m_in_frame) ferr_set = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(si);
                    m_in_frame = 1'b1;
                end else if (m_in_frame) begin
                    m_bits.push_back(si);
                    if (m_bits.size() == N) begin
                        for (int i = 0; i < N; i++) word += int'(m_bits[i]) << i;
                        done = 1'b1;
                        m_bits.delete();
                        m_in_frame = 1'b0;
                    end
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_dout  = N'(word);
                    m_valid = 1'b1;
                    $display("word 0x%0h loaded at t=%0t", word, $time);
                end else begin
                    ovr_set = 1'b1;
                    $display("word 0x%0h dropped (output full) at t=%0t", word, $time);
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            m_ovr  = ovr_set  | (m_ovr  & ~clr);
            m_ferr = ferr_set | (m_ferr & ~clr);
        end
    endtask

    task automatic cycle(input logic sv, input logic si, input logic fs,
                         input logic rdy, input logic clr, input logic rst);
        Ser_Valid   = sv;
        Ser_In      = si;
        Frame_Start = fs;
        Dout_Ready  = rdy;
        Clear_Err   = clr;
        Reset       = rst;
        @(posedge Clk);
        #1;
        model_step(sv, si, fs, rdy, clr, rst);
        check_val("dout",       32'(Dout),       32'(m_dout));
        check_val("dout_valid", 32'(Dout_Valid), 32'(m_valid));
        check_val("busy",       32'(Busy),       32'(m_in_frame));
        check_val("bit_count",  32'(Bit_Count),  32'(m_bits.size()));
        check_val("overrun",    32'(Overrun),    32'(m_ovr));
        check_val("frame_err",  32'(Frame_Err),  32'(m_ferr));
    endtask

    task automatic send_bits(input logic [N-1:0] w, input int nbits, input logic rdy);
        for (int i = 0; i < nbits; i++) cycle(1'b1, w[i], (i == 0), rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [N-1:0] w;

        // Reset state
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check_val("reset_dout", 32'(Dout), 32'h0);
        cycle(0, 0, 0, 0, 0, 0);

        // Plain frame, consumer always ready
        send_bits(8'hA5, 8, 1'b1);
        check_val("t1_dout", 32'(Dout), 32'hA5);
        check_val("t1_valid", 32'(Dout_Valid), 32'h1);
        cycle(0, 0, 0, 1, 0, 0);

        // Stray bits in IDLE, then a frame with a 3-cycle gap
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        w = 8'h3C;
        for (int i = 0; i < 3; i++) cycle(1, w[i], (i == 0), 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
        check_val("t2_hold_count", 32'(Bit_Count), 32'd3);
        for (int i = 3; i < N; i++) cycle(1, w[i], 0, 0, 0, 0);
        check_val("t2_dout", 32'(Dout), 32'h3C);
        cycle(0, 0, 0, 1, 0, 0);

        // Overrun, consume, clear
        send_bits(8'h11, 8, 1'b0);
        send_bits(8'h22, 8, 1'b0);
        check_val("t3_dout", 32'(Dout), 32'h11);
        check_val("t3_ovr", 32'(Overrun), 32'h1);
        cycle(0, 0, 0, 1, 0, 0);
        check_val("t3_consumed", 32'(Dout_Valid), 32'h0);
        cycle(0, 0, 0, 0, 1, 0);
        check_val("t3_cleared", 32'(Overrun), 32'h0);

        // Back-to-back frames with simultaneous consume and complete
        send_bits(8'hFF, 8, 1'b0);
        w = 8'h00;
        for (int i = 0; i < N; i++) cycle(1, w[i], (i == 0), (i == N - 1), 0, 0);
        check_val("t4_dout", 32'(Dout), 32'h00);
        check_val("t4_valid", 32'(Dout_Valid), 32'h1);
        check_val("t4_ovr", 32'(Overrun), 32'h0);
        cycle(0, 0, 0, 1, 0, 0);

        // Aborted frame
        send_bits(8'h0F, 4, 1'b1);
        send_bits(8'h81, 8, 1'b1);
        check_val("t5_ferr", 32'(Frame_Err), 32'h1);
        check_val("t5_dout", 32'(Dout), 32'h81);
        cycle(0, 0, 0, 1, 1, 0);

        // Reset mid-frame with a held word
        send_bits(8'h99, 8, 1'b0);
        send_bits(8'h55, 6, 1'b0);
        cycle(0, 0, 0, 0, 0, 1);
        check_val("t6_dout", 32'(Dout), 32'h0);
        check_val("t6_valid", 32'(Dout_Valid), 32'h0);
        w = 8'h55;
        for (int i = 0; i < N; i++) cycle(1, w[i], 0, 1, 0, 0);
        check_val("t6_busy", 32'(Busy), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
